// File: rtl/ramio_pkg.sv
// Shared widths, access-size encodings and FSM state type for the RAMIO port A arbiter.
package ramio_pkg;

  localparam int RAMIO_ADDR_WIDTH = 15;
  localparam int RAMIO_DATA_WIDTH = 32;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_BYTE = 2'b01;
  localparam logic [1:0] WE_HALF = 2'b10;
  localparam logic [1:0] WE_WORD = 2'b11;

  localparam logic [2:0] RE_NONE  = 3'b000;
  localparam logic [2:0] RE_UBYTE = 3'b001;
  localparam logic [2:0] RE_UHALF = 3'b010;
  localparam logic [2:0] RE_WORD  = 3'b111;
  localparam logic [2:0] RE_SBYTE = 3'b101;
  localparam logic [2:0] RE_SHALF = 3'b110;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    READ    = 2'd2,
    CAPTURE = 2'd3
  } arbState_t;

endpackage

// File: rtl/ramio_arbiter_if.sv
// One master's request channel into the RAMIO port A arbiter.
// Handshake: the master raises req with we/re/addr/din stable and holds them until ack;
// ack is a single-cycle pulse, rdata is valid with it and holds until that master's next read.
interface ramio_arbiter_if
  import ramio_pkg::*;
#(
  parameter int ADDR_WIDTH = RAMIO_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAMIO_DATA_WIDTH
);
  logic                  req;
  logic [1:0]            we;
  logic [2:0]            re;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, we, re, addr, din, input ack, rdata);
  modport slave  (input req, we, re, addr, din, output ack, rdata);
endinterface

// File: rtl/ramio_arbiter.sv
// Round-robin arbiter/sequencer between two masters for RAMIO port A.
// Every output comes straight from a register; the comb block only computes next values.
module ramio_arbiter
  import ramio_pkg::*;
#(
  parameter int ADDR_WIDTH = RAMIO_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAMIO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  ramio_arbiter_if.slave        m0,
  ramio_arbiter_if.slave        m1,
  output logic [1:0]            ram_we,
  output logic [2:0]            ram_re,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy,
  output arbState_t             dbgState
);

  arbState_t             state, nState;
  logic                  lastGrant, nLastGrant;
  logic                  cur, nCur;
  logic [1:0]            ramWe, nRamWe;
  logic [2:0]            ramRe, nRamRe;
  logic [ADDR_WIDTH-1:0] ramAddr, nRamAddr;
  logic [DATA_WIDTH-1:0] ramDin, nRamDin;
  logic                  ack0, nAck0, ack1, nAck1;
  logic [DATA_WIDTH-1:0] rdata0, nRdata0, rdata1, nRdata1;
  logic                  busyQ, nBusy;

  // m1 wins when it is alone, or when both ask and m0 had the last grant.
  logic                  anyReq, grant;
  logic [1:0]            selWe;
  logic [2:0]            selRe;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic [DATA_WIDTH-1:0] selDin;

  assign anyReq  = m0.req | m1.req;
  assign grant   = m1.req & (~m0.req | ~lastGrant);
  assign selWe   = grant ? m1.we   : m0.we;
  assign selRe   = grant ? m1.re   : m0.re;
  assign selAddr = grant ? m1.addr : m0.addr;
  assign selDin  = grant ? m1.din  : m0.din;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lastGrant <= 1'b1;
      cur       <= 1'b0;
      ramWe     <= WE_NONE;
      ramRe     <= RE_NONE;
      ramAddr   <= '0;
      ramDin    <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      busyQ     <= 1'b0;
    end else begin
      state     <= nState;
      lastGrant <= nLastGrant;
      cur       <= nCur;
      ramWe     <= nRamWe;
      ramRe     <= nRamRe;
      ramAddr   <= nRamAddr;
      ramDin    <= nRamDin;
      ack0      <= nAck0;
      ack1      <= nAck1;
      rdata0    <= nRdata0;
      rdata1    <= nRdata1;
      busyQ     <= nBusy;
    end
  end

  always_comb begin
    nState     = state;
    nLastGrant = lastGrant;
    nCur       = cur;
    nRamWe     = ramWe;
    nRamRe     = ramRe;
    nRamAddr   = ramAddr;
    nRamDin    = ramDin;
    nAck0      = 1'b0;
    nAck1      = 1'b0;
    nRdata0    = rdata0;
    nRdata1    = rdata1;

    unique case (state)
      IDLE: begin
        if (anyReq) begin
          nLastGrant = grant;
          nCur       = grant;
          nRamAddr   = selAddr;
          nRamDin    = selDin;
          if (selWe != WE_NONE) begin
            nRamWe = selWe;
            nRamRe = RE_NONE;
            nState = WRITE;
          end else if (selRe != RE_NONE) begin
            nRamWe = WE_NONE;
            nRamRe = selRe;
            nState = READ;
          end else begin
            // No-op: acknowledge right away without touching the RAM.
            nRamWe = WE_NONE;
            nRamRe = RE_NONE;
            nAck0  = ~grant;
            nAck1  = grant;
          end
        end
      end
      WRITE: begin
        nRamWe = WE_NONE;
        nAck0  = ~cur;
        nAck1  = cur;
        nState = IDLE;
      end
      READ: begin
        nRamRe = RE_NONE;
        nState = CAPTURE;
      end
      CAPTURE: begin
        if (cur) nRdata1 = ram_dout;
        else     nRdata0 = ram_dout;
        nAck0  = ~cur;
        nAck1  = cur;
        nState = IDLE;
      end
      default: nState = IDLE;
    endcase

    nBusy = (nState != IDLE);
  end

  assign ram_we   = ramWe;
  assign ram_re   = ramRe;
  assign ram_addr = ramAddr;
  assign ram_din  = ramDin;
  assign busy     = busyQ;
  assign dbgState = state;
  assign m0.ack   = ack0;
  assign m1.ack   = ack1;
  assign m0.rdata = rdata0;
  assign m1.rdata = rdata1;

endmodule
